dcache_axi_port: RTL and testbench

DCACHE_AXI_PORT -- requirements
Module: dcache_axi_port

---
 rtl/dcache_axi_port_pkg.sv | 26 ++
 rtl/dcache_axi_port.sv | 196 +++++++++++++++++++
 tb/tb_dcache_axi_port.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_axi_port_pkg.sv
// Shared cache/arbiter defines: data-cache port widths, AXI port FSM encoding
// and the fixed single-beat AXI burst fields.
package dcache_axi_port_pkg;

   localparam int DADDR_W       = 32;
   localparam int DCACHE_DATA_W = 32;
   localparam int DCACHE_WEN_W  = 4;

   localparam int STATE_W = 3;
   localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
   localparam logic [STATE_W-1:0] ST_AR   = 3'd1;
   localparam logic [STATE_W-1:0] ST_R    = 3'd2;
   localparam logic [STATE_W-1:0] ST_AW_W = 3'd3;
   localparam logic [STATE_W-1:0] ST_B    = 3'd4;
   localparam logic [STATE_W-1:0] ST_DONE = 3'd5;
   localparam logic [STATE_W-1:0] ST_HOLD = 3'd6;

   localparam logic [7:0] AXI_LEN  = 8'd0;
   localparam logic [2:0] AXI_SIZE = 3'b010;

   // Word-aligns a byte address; every transfer is one full 32-bit beat.
   function automatic logic [DADDR_W-1:0] word_align(input logic [DADDR_W-1:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/dcache_axi_port.sv
// Single-beat AXI master for the data cache: one read or one write per request,
// with a one-cycle HOLD after completion and an optional wait-state watchdog.
module dcache_axi_port
   import dcache_axi_port_pkg::*;
#(
   parameter logic [3:0]  AXI_ID     = 4'd1,
   parameter int unsigned RD_TIMEOUT = 32'd0
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     data_cache_req,
   input  logic [DADDR_W-1:0]       data_sram_addr,
   input  logic [DCACHE_WEN_W-1:0]  data_sram_wen,
   input  logic [DCACHE_DATA_W-1:0] data_sram_wdata,
   output logic [DCACHE_DATA_W-1:0] data_cache_rdata,
   output logic                     data_cache_dok,
   output logic [3:0]               arid,
   output logic [DADDR_W-1:0]       araddr,
   output logic [7:0]               arlen,
   output logic [2:0]               arsize,
   output logic                     arvalid,
   input  logic                     arready,
   input  logic [DCACHE_DATA_W-1:0] rdata,
   input  logic [1:0]               rresp,
   input  logic                     rlast,
   input  logic                     rvalid,
   output logic                     rready,
   output logic [3:0]               awid,
   output logic [DADDR_W-1:0]       awaddr,
   output logic [7:0]               awlen,
   output logic [2:0]               awsize,
   output logic                     awvalid,
   input  logic                     awready,
   output logic [DCACHE_DATA_W-1:0] wdata,
   output logic [DCACHE_WEN_W-1:0]  wstrb,
   output logic                     wlast,
   output logic                     wvalid,
   input  logic                     wready,
   input  logic [1:0]               bresp,
   input  logic                     bvalid,
   output logic                     bready,
   output logic                     err
);

   localparam logic        TMO_EN   = (RD_TIMEOUT != 32'd0);
   localparam logic [31:0] TMO_LAST = 32'(RD_TIMEOUT) - 32'd1;

   logic [STATE_W-1:0]       state_r, state_nxt_s;
   logic [DADDR_W-1:0]       addr_r;
   logic [DCACHE_WEN_W-1:0]  wen_r;
   logic [DCACHE_DATA_W-1:0] wdata_r, rdata_r;
   logic [31:0]              tmo_r;
   logic arvalid_r, rready_r, awvalid_r, wvalid_r, bready_r, dok_r, err_r;
   logic aw_done_r, w_done_r, aw_done_nxt_s, w_done_nxt_s;
   logic resp_err_s, tmo_s, tmo_hit_s;
   logic rlast_unused_s;

   // Single-beat bursts always end on the first beat, so rlast carries no information.
   assign rlast_unused_s = rlast;
   assign tmo_hit_s      = TMO_EN && (tmo_r == TMO_LAST);

   // Next-state, per-channel handshake tracking and error/timeout detection.
   always_comb begin
      state_nxt_s   = state_r;
      aw_done_nxt_s = aw_done_r;
      w_done_nxt_s  = w_done_r;
      resp_err_s    = 1'b0;
      tmo_s         = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (data_cache_req) begin
               state_nxt_s   = (data_sram_wen == 4'b0000) ? ST_AR : ST_AW_W;
               aw_done_nxt_s = 1'b0;
               w_done_nxt_s  = 1'b0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_AR: begin
            if (arvalid_r && arready) begin
               state_nxt_s = ST_R;
            end else if (tmo_hit_s) begin
               state_nxt_s = ST_DONE;
               tmo_s       = 1'b1;
            end else begin
               state_nxt_s = ST_AR;
            end
         end
         ST_R: begin
            if (rready_r && rvalid) begin
               state_nxt_s = ST_DONE;
               resp_err_s  = (rresp != 2'b00);
            end else if (tmo_hit_s) begin
               state_nxt_s = ST_DONE;
               tmo_s       = 1'b1;
            end else begin
               state_nxt_s = ST_R;
            end
         end
         ST_AW_W: begin
            // Address and data may complete in either order or together.
            aw_done_nxt_s = aw_done_r | (awvalid_r & awready);
            w_done_nxt_s  = w_done_r | (wvalid_r & wready);
            if (aw_done_nxt_s && w_done_nxt_s) begin
               state_nxt_s = ST_B;
            end else if (tmo_hit_s) begin
               state_nxt_s = ST_DONE;
               tmo_s       = 1'b1;
            end else begin
               state_nxt_s = ST_AW_W;
            end
         end
         ST_B: begin
            if (bready_r && bvalid) begin
               state_nxt_s = ST_DONE;
               resp_err_s  = (bresp != 2'b00);
            end else if (tmo_hit_s) begin
               state_nxt_s = ST_DONE;
               tmo_s       = 1'b1;
            end else begin
               state_nxt_s = ST_B;
            end
         end
         ST_DONE: state_nxt_s = ST_HOLD;
         ST_HOLD: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, registered AXI controls, request latches, read data and sticky error.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r   <= ST_IDLE;
         addr_r    <= 32'd0;
         wen_r     <= 4'd0;
         wdata_r   <= 32'd0;
         rdata_r   <= 32'd0;
         tmo_r     <= 32'd0;
         arvalid_r <= 1'b0;
         rready_r  <= 1'b0;
         awvalid_r <= 1'b0;
         wvalid_r  <= 1'b0;
         bready_r  <= 1'b0;
         dok_r     <= 1'b0;
         err_r     <= 1'b0;
         aw_done_r <= 1'b0;
         w_done_r  <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         aw_done_r <= aw_done_nxt_s;
         w_done_r  <= w_done_nxt_s;
         // Counts cycles spent in the current state; restarts on every transition.
         tmo_r     <= (state_nxt_s == state_r) ? tmo_r + 32'd1 : 32'd0;
         arvalid_r <= (state_nxt_s == ST_AR);
         rready_r  <= (state_nxt_s == ST_R);
         awvalid_r <= (state_nxt_s == ST_AW_W) && !aw_done_nxt_s;
         wvalid_r  <= (state_nxt_s == ST_AW_W) && !w_done_nxt_s;
         bready_r  <= (state_nxt_s == ST_B);
         dok_r     <= (state_nxt_s == ST_DONE);
         if (resp_err_s || tmo_s) begin
            err_r <= 1'b1;
         end
         if (state_r == ST_IDLE && data_cache_req) begin
            addr_r  <= word_align(data_sram_addr);
            wen_r   <= data_sram_wen;
            wdata_r <= data_sram_wdata;
         end
         if (state_r == ST_R && rready_r && rvalid) begin
            rdata_r <= rdata;
         end else if (tmo_s && (state_r == ST_AR || state_r == ST_R)) begin
            rdata_r <= 32'd0;
         end
      end
   end

   assign data_cache_rdata = rdata_r;
   assign data_cache_dok   = dok_r;
   assign err              = err_r;
   assign arid             = AXI_ID;
   assign araddr           = addr_r;
   assign arlen            = AXI_LEN;
   assign arsize           = AXI_SIZE;
   assign arvalid          = arvalid_r;
   assign rready           = rready_r;
   assign awid             = AXI_ID;
   assign awaddr           = addr_r;
   assign awlen            = AXI_LEN;
   assign awsize           = AXI_SIZE;
   assign awvalid          = awvalid_r;
   assign wdata            = wdata_r;
   assign wstrb            = wen_r;
   assign wlast            = 1'b1;
   assign wvalid           = wvalid_r;
   assign bready           = bready_r;

endmodule

// File: tb/tb_dcache_axi_port.sv
// Bench for dcache_axi_port: table of single transactions against a delay-programmable
// AXI slave model, plus hand-written HOLD, reset and timeout sequences.
module tb_dcache_axi_port;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn, req, dok, err;
   logic [31:0] addr, wdata_in, rdata_out;
   logic [3:0]  wen;
   logic [3:0]  arid, awid;
   logic [31:0] araddr, awaddr, rdata, wdata;
   logic [7:0]  arlen, awlen;
   logic [2:0]  arsize, awsize;
   logic        arvalid, arready, rvalid, rready, rlast;
   logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic [1:0]  rresp, bresp;
   logic [3:0]  wstrb;

   dcache_axi_port #(.AXI_ID(4'd1), .RD_TIMEOUT(8)) dut (
      .clk(clk), .resetn(resetn), .data_cache_req(req), .data_sram_addr(addr),
      .data_sram_wen(wen), .data_sram_wdata(wdata_in), .data_cache_rdata(rdata_out),
      .data_cache_dok(dok), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
      .awsize(awsize), .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
      .wlast(wlast), .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid),
      .bready(bready), .err(err)
   );

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [3:0]  wen;
      logic [31:0] wdata;
      logic [31:0] sl_rdata;
      logic [1:0]  rresp;
      logic [1:0]  bresp;
      int          ar_d, r_d, aw_d, w_d, b_d;
      bit          ar_block;
      logic [31:0] exp_addr;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat, exp_av, exp_w;
   } row_t;

   // slave configuration (written by the main sequence only)
   int          cfg_ar_d, cfg_r_d, cfg_aw_d, cfg_w_d, cfg_b_d;
   bit          cfg_ar_block;
   logic [31:0] cfg_rdata;
   logic [1:0]  cfg_rresp, cfg_bresp;

   // slave observations (written by the slave process only)
   int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
   bit          ar_prev, aw_prev, w_prev;
   logic [31:0] ar_hold, aw_hold, w_hold;
   logic [3:0]  s_hold;
   int          ar_hi_total, aw_hi_total, w_hi_total, ar_starts, stable_bad;
   logic [31:0] ar_seen, aw_seen, last_wdata;
   logic [3:0]  last_wstrb;

   int   total, bad;
   row_t exp_q[$];
   row_t rows[7];

   // AXI slave: ready/valid after a programmed number of waiting cycles, with stability tracking.
   initial begin
      arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      ar_prev = 1'b0; aw_prev = 1'b0; w_prev = 1'b0;
      ar_hold = 32'd0; aw_hold = 32'd0; w_hold = 32'd0; s_hold = 4'd0;
      ar_hi_total = 0; aw_hi_total = 0; w_hi_total = 0; ar_starts = 0; stable_bad = 0;
      ar_seen = 32'd0; aw_seen = 32'd0; last_wdata = 32'd0; last_wstrb = 4'd0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            ar_prev = 1'b0; aw_prev = 1'b0; w_prev = 1'b0;
         end else begin
            if (arvalid) begin
               ar_hi_total++;
               if (!ar_prev) begin ar_starts++; ar_seen = araddr; end
               else if (araddr !== ar_hold) stable_bad++;
               ar_hold = araddr;
               arready = !cfg_ar_block && (ar_cnt >= cfg_ar_d);
               ar_cnt++;
            end else begin
               arready = 1'b0; ar_cnt = 0;
            end
            ar_prev = arvalid;
            rvalid = rready && (r_cnt >= cfg_r_d);
            rlast  = rvalid;
            rdata  = cfg_rdata;
            rresp  = cfg_rresp;
            r_cnt  = rready ? r_cnt + 1 : 0;
            if (awvalid) begin
               aw_hi_total++;
               if (!aw_prev) aw_seen = awaddr;
               else if (awaddr !== aw_hold) stable_bad++;
               aw_hold = awaddr;
               awready = (aw_cnt >= cfg_aw_d);
               aw_cnt++;
            end else begin
               awready = 1'b0; aw_cnt = 0;
            end
            aw_prev = awvalid;
            if (wvalid) begin
               w_hi_total++;
               if (!w_prev) begin last_wdata = wdata; last_wstrb = wstrb; end
               else if (wdata !== w_hold || wstrb !== s_hold) stable_bad++;
               w_hold = wdata; s_hold = wstrb;
               wready = (w_cnt >= cfg_w_d);
               w_cnt++;
            end else begin
               wready = 1'b0; w_cnt = 0;
            end
            w_prev = wvalid;
            bvalid = bready && (b_cnt >= cfg_b_d);
            bresp  = cfg_bresp;
            b_cnt  = bready ? b_cnt + 1 : 0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic row_t mk(input bit wr, input logic [31:0] a, input logic [3:0] we,
                               input logic [31:0] wd, input logic [31:0] srd,
                               input logic [1:0] rr, input logic [1:0] br,
                               input int ard, input int rd, input int awd, input int wd_d,
                               input int bd, input bit blk, input logic [31:0] ea,
                               input logic [31:0] erd, input logic ee, input int el,
                               input int eav, input int ew);
      row_t r;
      r.wr = wr; r.addr = a; r.wen = we; r.wdata = wd; r.sl_rdata = srd;
      r.rresp = rr; r.bresp = br; r.ar_d = ard; r.r_d = rd; r.aw_d = awd; r.w_d = wd_d;
      r.b_d = bd; r.ar_block = blk; r.exp_addr = ea; r.exp_rdata = erd; r.exp_err = ee;
      r.exp_lat = el; r.exp_av = eav; r.exp_w = ew;
      return r;
   endfunction

   // Drives one request at a negedge, scrambles the inputs after acceptance, checks at dok.
   task automatic run_txn(input row_t v, input bit keep_req);
      int   lat;
      int   ar0, aw0, w0;
      bit   got;
      row_t e;
      cfg_ar_d = v.ar_d; cfg_r_d = v.r_d; cfg_aw_d = v.aw_d; cfg_w_d = v.w_d; cfg_b_d = v.b_d;
      cfg_ar_block = v.ar_block; cfg_rdata = v.sl_rdata; cfg_rresp = v.rresp; cfg_bresp = v.bresp;
      ar0 = ar_hi_total; aw0 = aw_hi_total; w0 = w_hi_total;
      exp_q.push_back(v);
      req = 1'b1; addr = v.addr; wen = v.wr ? v.wen : 4'h0; wdata_in = v.wdata;
      lat = 0; got = 1'b0;
      while (!got && lat < 100) begin
         @(negedge clk);
         lat++;
         if (lat == 1 && !keep_req) begin
            addr = ~v.addr; wdata_in = ~v.wdata; wen = v.wr ? 4'h0 : 4'hF;
         end
         if (dok) got = 1'b1;
      end
      e = exp_q.pop_front();
      if (!got) begin
         total++; bad++;
         $display("FAIL dok_wait: actual=no dok required=dok within 100 cycles");
         req = 1'b0;
      end else begin
         if (!keep_req) req = 1'b0;
         chk("latency", 32'(lat), 32'(e.exp_lat));
         chk("rdata", rdata_out, e.exp_rdata);
         chk("err", 32'(err), 32'(e.exp_err));
         chk("axi_addr", e.wr ? aw_seen : ar_seen, e.exp_addr);
         chk("addr_valid_cycles", e.wr ? 32'(aw_hi_total - aw0) : 32'(ar_hi_total - ar0), 32'(e.exp_av));
         chk("wvalid_cycles", 32'(w_hi_total - w0), 32'(e.exp_w));
         if (e.wr) begin
            chk("wstrb", 32'(last_wstrb), 32'(e.wen));
            chk("wdata", last_wdata, e.wdata);
         end
         @(negedge clk);
         chk("dok_width", 32'(dok), 32'd0);
         if (!keep_req) @(negedge clk);
      end
   endtask

   task automatic apply_reset();
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int   n, s0;
      logic d;
      total = 0; bad = 0;
      resetn = 1'b0; req = 1'b0; addr = 32'd0; wen = 4'd0; wdata_in = 32'd0;
      cfg_ar_d = 0; cfg_r_d = 0; cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 0; cfg_ar_block = 1'b0;
      cfg_rdata = 32'd0; cfg_rresp = 2'b00; cfg_bresp = 2'b00;

      //       wr    addr          wen    wdata         slave rdata   rr     br     ar r aw w b blk  exp_addr      exp_rdata     err  lat av w
      rows[0] = mk(1'b0, 32'h8000_1004, 4'h0, 32'h0,        32'hDEAD_BEEF, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1'b0, 32'h8000_1004, 32'hDEAD_BEEF, 1'b0, 3, 1, 0);
      rows[1] = mk(1'b1, 32'h1000_0002, 4'h3, 32'h1234_5678, 32'h0,        2'b00, 2'b00, 0, 0, 2, 0, 0, 1'b0, 32'h1000_0000, 32'hDEAD_BEEF, 1'b0, 5, 3, 1);
      rows[2] = mk(1'b0, 32'h0000_0FFF, 4'h0, 32'h0,        32'hA5A5_5A5A, 2'b00, 2'b00, 1, 2, 0, 0, 0, 1'b0, 32'h0000_0FFC, 32'hA5A5_5A5A, 1'b0, 6, 2, 0);
      rows[3] = mk(1'b1, 32'h2000_0010, 4'hF, 32'hCAFE_F00D, 32'h0,        2'b00, 2'b00, 0, 0, 0, 3, 1, 1'b0, 32'h2000_0010, 32'hA5A5_5A5A, 1'b0, 7, 1, 4);
      rows[4] = mk(1'b0, 32'h4000_0020, 4'h0, 32'h0,        32'h0BAD_F00D, 2'b00, 2'b00, 7, 0, 0, 0, 0, 1'b0, 32'h4000_0020, 32'h0BAD_F00D, 1'b0, 10, 8, 0);
      rows[5] = mk(1'b0, 32'h5000_0004, 4'h0, 32'h0,        32'h1111_2222, 2'b10, 2'b00, 0, 0, 0, 0, 0, 1'b0, 32'h5000_0004, 32'h1111_2222, 1'b1, 3, 1, 0);
      rows[6] = mk(1'b1, 32'h6000_0007, 4'hC, 32'h89AB_CDEF, 32'h0,        2'b00, 2'b00, 0, 0, 0, 0, 0, 1'b0, 32'h6000_0004, 32'h1111_2222, 1'b1, 3, 1, 1);

      repeat (2) @(negedge clk);
      chk("rst_dok", 32'(dok), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rdata", rdata_out, 32'd0);
      chk("rst_valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
      chk("rst_araddr", araddr, 32'd0);
      chk("fixed_ids", {24'd0, arid, awid}, 32'h0000_0011);
      chk("fixed_len_size", {10'd0, arlen, awlen, arsize, awsize}, {10'd0, 8'd0, 8'd0, 3'b010, 3'b010});
      chk("fixed_wlast", 32'(wlast), 32'd1);
      resetn = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) run_txn(rows[i], 1'b0);

      // req held across dok: nothing may be issued in HOLD, a new read starts after it
      run_txn(mk(1'b0, 32'h3000_0008, 4'h0, 32'h0, 32'h5555_AAAA, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1'b0,
                 32'h3000_0008, 32'h5555_AAAA, 1'b1, 3, 1, 0), 1'b1);
      s0 = ar_starts;
      chk("hold_arvalid", 32'(arvalid), 32'd0);
      @(negedge clk);
      chk("idle_arvalid", 32'(arvalid), 32'd0);
      @(negedge clk);
      chk("reissue_arvalid", 32'(arvalid), 32'd1);
      cfg_rdata = 32'h6666_9999;
      n = 0;
      while (!dok && n < 50) begin @(negedge clk); n++; end
      req = 1'b0;
      chk("reissue_dok", 32'(dok), 32'd1);
      chk("reissue_rdata", rdata_out, 32'h6666_9999);
      chk("reissue_ar_count", 32'(ar_starts - s0), 32'd1);
      repeat (2) @(negedge clk);

      // reset while waiting in R
      cfg_r_d = 20; cfg_ar_d = 0; cfg_rdata = 32'h0F0F_0F0F;
      req = 1'b1; addr = 32'h7000_0000; wen = 4'h0;
      n = 0;
      while (!rready && n < 20) begin @(negedge clk); n++; end
      chk("reach_r", 32'(rready), 32'd1);
      req = 1'b0;
      #2 resetn = 1'b0;
      #1;
      chk("midrst_valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
      chk("midrst_dok_err", {30'd0, dok, err}, 32'd0);
      chk("midrst_rdata", rdata_out, 32'd0);
      chk("midrst_araddr", araddr, 32'd0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      d = 1'b0;
      repeat (5) begin @(negedge clk); d = d | dok; end
      chk("no_dok_after_reset", 32'(d), 32'd0);
      run_txn(mk(1'b0, 32'h0800_0010, 4'h0, 32'h0, 32'h7777_1234, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1'b0,
                 32'h0800_0010, 32'h7777_1234, 1'b0, 3, 1, 0), 1'b0);

      // error write response: completes, sets err, which then stays set
      run_txn(mk(1'b1, 32'h0900_0000, 4'hF, 32'hFEED_FACE, 32'h0, 2'b00, 2'b10, 0, 0, 0, 0, 0, 1'b0,
                 32'h0900_0000, 32'h7777_1234, 1'b1, 3, 1, 1), 1'b0);
      run_txn(mk(1'b0, 32'h0A00_0004, 4'h0, 32'h0, 32'h0102_0304, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1'b0,
                 32'h0A00_0004, 32'h0102_0304, 1'b1, 3, 1, 0), 1'b0);

      // watchdog: arready never comes
      apply_reset();
      run_txn(mk(1'b0, 32'h0B00_0000, 4'h0, 32'h0, 32'h7777_1234, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1'b0,
                 32'h0B00_0000, 32'h7777_1234, 1'b0, 3, 1, 0), 1'b0);
      run_txn(mk(1'b0, 32'h0C00_0008, 4'h0, 32'h0, 32'hFFFF_FFFF, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1'b1,
                 32'h0C00_0008, 32'h0000_0000, 1'b1, 9, 8, 0), 1'b0);

      chk("valid_payload_stable", 32'(stable_bad), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
